// File: rtl/sample_and_hold_nch.sv
// Multi-channel sample-and-hold / peak detector.
// Decimates NCHAN packed unsigned channels to one value per window. Each
// window yields a snapshot, a running max, a running min, or a frozen output.
// A free-running window counter marks window boundaries, and sync re-aligns it.
module sample_and_hold_nch #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned NCHAN       = 4,
  parameter int unsigned PERIOD_BITS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sync,
  input  logic [PERIOD_BITS-1:0]   period_m1,
  input  logic [1:0]               mode,
  input  logic [NCHAN*WIDTH-1:0]   din,
  output logic [NCHAN*WIDTH-1:0]   dout,
  output logic                     dout_valid,
  output logic [1:0]               active_mode
);

  typedef enum logic [1:0] {
    MODE_SNAP   = 2'd0,
    MODE_MAX    = 2'd1,
    MODE_MIN    = 2'd2,
    MODE_FREEZE = 2'd3
  } mode_e;

  logic [PERIOD_BITS-1:0] r_ctr;
  logic                   r_ev_d;
  mode_e                  r_mode;
  logic [NCHAN*WIDTH-1:0] r_acc;
  logic [NCHAN*WIDTH-1:0] r_dout;
  logic                   r_dout_valid;

  logic                   w_event;
  mode_e                  w_mode_in;
  logic [NCHAN*WIDTH-1:0] w_max;
  logic [NCHAN*WIDTH-1:0] w_min;
  logic [NCHAN*WIDTH-1:0] w_result;
  logic [NCHAN*WIDTH-1:0] w_hold;
  logic [NCHAN*WIDTH-1:0] w_seed;

  assign w_mode_in = mode_e'(mode);

  // Using >= rather than == makes a shrinking period end the window at once.
  assign w_event = sync | (r_ctr >= period_m1);

  // Per-channel unsigned max/min of the running peak against the current sample.
  for (genvar k = 0; k < NCHAN; k++) begin : g_ch
    logic [WIDTH-1:0] w_d;
    logic [WIDTH-1:0] w_a;
    assign w_d = din[k*WIDTH +: WIDTH];
    assign w_a = r_acc[k*WIDTH +: WIDTH];
    assign w_max[k*WIDTH +: WIDTH] = (w_d > w_a) ? w_d : w_a;
    assign w_min[k*WIDTH +: WIDTH] = (w_d < w_a) ? w_d : w_a;
  end

  // Window counter and one-cycle delayed event that marks the close cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctr  <= '0;
      r_ev_d <= 1'b0;
    end else begin
      r_ev_d <= w_event;
      r_ctr  <= w_event ? '0 : r_ctr + 1'b1;
    end
  end

  // Window result and accumulator update under the mode currently in force.
  always_comb begin
    w_result = r_dout;
    w_hold   = r_acc;
    case (r_mode)
      MODE_SNAP: begin
        w_result = din;
      end
      MODE_MAX: begin
        w_result = w_max;
        w_hold   = w_max;
      end
      MODE_MIN: begin
        w_result = w_min;
        w_hold   = w_min;
      end
      default: begin
      end
    endcase
  end

  // Accumulator re-seed value for the mode being latched at a close.
  always_comb begin
    w_seed = '0;
    if (w_mode_in == MODE_MIN) w_seed = '1;
  end

  // Close cycle: publish the result, latch the new mode, re-seed the accumulators.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_mode       <= MODE_SNAP;
      r_acc        <= '0;
    end else begin
      r_dout_valid <= 1'b0;
      if (r_ev_d) begin
        r_dout       <= w_result;
        r_dout_valid <= (r_mode != MODE_FREEZE);
        r_mode       <= w_mode_in;
        r_acc        <= w_seed;
      end else begin
        r_acc        <= w_hold;
      end
    end
  end

  assign dout        = r_dout;
  assign dout_valid  = r_dout_valid;
  assign active_mode = r_mode;

endmodule

// File: tb/tb_sample_and_hold_nch.sv
// Directed testbench for sample_and_hold_nch (WIDTH=8, NCHAN=4, PERIOD_BITS=8).
// Cycle c = interval after the c-th clock edge following reset release;
// outputs are sampled 1 time unit after the edge, inputs driven right after.
module tb_sample_and_hold_nch;

  logic        clk = 1'b0;
  logic        rst;
  logic        sync;
  logic [7:0]  period_m1;
  logic [1:0]  mode;
  logic [31:0] din;
  logic [31:0] dout;
  logic        dout_valid;
  logic [1:0]  active_mode;

  int checks = 0;
  int errors = 0;

  sample_and_hold_nch #(
    .WIDTH(8),
    .NCHAN(4),
    .PERIOD_BITS(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sync(sync),
    .period_m1(period_m1),
    .mode(mode),
    .din(din),
    .dout(dout),
    .dout_valid(dout_valid),
    .active_mode(active_mode)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
    logic [7:0] a8, b8, c8, d8;
    a8 = a[7:0]; b8 = b[7:0]; c8 = c[7:0]; d8 = d[7:0];
    return {d8, c8, b8, a8};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0 with rst just released.
  task automatic do_reset(input logic [7:0] p, input logic [1:0] m);
    rst = 1'b1; sync = 1'b0; period_m1 = p; mode = m; din = '0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; sync = 1'b1; period_m1 = 8'd0; mode = 2'd1; din = '1;
    tick;
    tick;
    checks++;
    if (dout !== 32'h0) begin errors++; $display("FAIL reset_dout got %h exp %h", dout, 32'h0); end
    checks++;
    if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", dout_valid); end
    checks++;
    if (active_mode !== 2'd0) begin errors++; $display("FAIL reset_mode got %0d exp 0", active_mode); end
  endtask

  task automatic test_snapshot;
    logic        exp_v;
    logic [31:0] exp_d;
    int          lc;
    do_reset(8'd3, 2'd0);
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) tick;
      exp_v = (c >= 5) && ((c - 5) % 4 == 0);
      lc    = ((c - 1) / 4) * 4;
      exp_d = (c >= 5) ? pk(lc, 16 + lc, 32 + lc, 48 + lc) : 32'h0;
      checks++;
      if (dout_valid !== exp_v) begin errors++; $display("FAIL snap_valid c=%0d got %b exp %b", c, dout_valid, exp_v); end
      checks++;
      if (dout !== exp_d) begin errors++; $display("FAIL snap_dout c=%0d got %h exp %h", c, dout, exp_d); end
      din = pk(c, 16 + c, 32 + c, 48 + c);
    end
  endtask

  task automatic test_period_zero;
    do_reset(8'd0, 2'd0);
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) tick;
      checks++;
      if (dout_valid !== (c >= 2)) begin errors++; $display("FAIL p0_valid c=%0d got %b exp %b", c, dout_valid, (c >= 2)); end
      if (c >= 2) begin
        checks++;
        if (dout !== pk(c - 1, c, c + 1, c + 2)) begin errors++; $display("FAIL p0_dout c=%0d got %h exp %h", c, dout, pk(c - 1, c, c + 1, c + 2)); end
      end
      din = pk(c, c + 1, c + 2, c + 3);
    end
  endtask

  task automatic test_max_min;
    logic [7:0]  seq [8];
    logic        exp_v;
    int          i;
    seq = '{8'd5, 8'd9, 8'd2, 8'd200, 8'd7, 8'd1, 8'd3, 8'd4};
    do_reset(8'd7, 2'd1);
    for (int c = 0; c <= 33; c++) begin
      if (c > 0) tick;
      exp_v = (c == 9) || (c == 17) || (c == 25) || (c == 33);
      checks++;
      if (dout_valid !== exp_v) begin errors++; $display("FAIL mm_valid c=%0d got %b exp %b", c, dout_valid, exp_v); end
      if (c == 9) begin
        checks++;
        if (dout !== 32'h33333333) begin errors++; $display("FAIL mm_first_snap got %h exp %h", dout, 32'h33333333); end
        checks++;
        if (active_mode !== 2'd1) begin errors++; $display("FAIL mm_mode_max got %0d exp 1", active_mode); end
      end
      if (c == 16) begin
        checks++;
        if (active_mode !== 2'd1) begin errors++; $display("FAIL mm_mode_not_yet got %0d exp 1", active_mode); end
      end
      if (c == 17) begin
        checks++;
        if (dout !== pk(200, 200, 0, 0)) begin errors++; $display("FAIL mm_max got %h exp %h", dout, pk(200, 200, 0, 0)); end
        checks++;
        if (active_mode !== 2'd2) begin errors++; $display("FAIL mm_mode_min got %0d exp 2", active_mode); end
      end
      if (c == 25) begin
        checks++;
        if (dout !== pk(1, 1, 0, 0)) begin errors++; $display("FAIL mm_min got %h exp %h", dout, pk(1, 1, 0, 0)); end
      end
      if (c == 33) begin
        checks++;
        if (dout !== pk(50, 60, 0, 0)) begin errors++; $display("FAIL mm_reseed got %h exp %h", dout, pk(50, 60, 0, 0)); end
      end
      mode = (c < 12) ? 2'd1 : 2'd2;
      if (c <= 8) din = 32'h33333333;
      else if (c <= 24) begin
        i   = (c <= 16) ? c - 9 : c - 17;
        din = pk(seq[i], seq[7 - i], 0, 0);
      end else din = pk(50, 60, 0, 0);
    end
  endtask

  task automatic test_sync;
    logic exp_v;
    do_reset(8'd9, 2'd0);
    for (int c = 0; c <= 30; c++) begin
      if (c > 0) tick;
      exp_v = (c == 4) || (c == 14) || (c == 18) || (c == 19) || (c == 20) || (c == 30);
      checks++;
      if (dout_valid !== exp_v) begin errors++; $display("FAIL sync_valid c=%0d got %b exp %b", c, dout_valid, exp_v); end
      if (exp_v) begin
        checks++;
        if (dout !== pk(c - 1, 15 + c, 31 + c, 47 + c)) begin errors++; $display("FAIL sync_dout c=%0d got %h exp %h", c, dout, pk(c - 1, 15 + c, 31 + c, 47 + c)); end
      end
      sync = (c == 2) || (c == 12) || (c == 16) || (c == 17) || (c == 18);
      din  = pk(c, 16 + c, 32 + c, 48 + c);
    end
    sync = 1'b0;
  endtask

  task automatic test_shrink;
    logic exp_v;
    do_reset(8'd99, 2'd0);
    for (int c = 0; c <= 85; c++) begin
      if (c > 0) tick;
      exp_v = (c == 52) || (c == 63) || (c == 74) || (c == 85);
      checks++;
      if (dout_valid !== exp_v) begin errors++; $display("FAIL shrink_valid c=%0d got %b exp %b", c, dout_valid, exp_v); end
      if (c == 52) begin
        checks++;
        if (dout !== pk(51, 52, 53, 54)) begin errors++; $display("FAIL shrink_dout got %h exp %h", dout, pk(51, 52, 53, 54)); end
      end
      period_m1 = (c >= 50) ? 8'd10 : 8'd99;
      din = pk(c, c + 1, c + 2, c + 3);
    end
  endtask

  task automatic test_freeze;
    logic        exp_v;
    logic [31:0] exp_d;
    logic [1:0]  exp_m;
    int          v;
    do_reset(8'd3, 2'd1);
    for (int c = 0; c <= 25; c++) begin
      if (c > 0) tick;
      exp_v = (c == 5) || (c == 9) || (c == 25);
      exp_m = (c < 5) ? 2'd0 : (c < 9) ? 2'd1 : (c < 21) ? 2'd3 : 2'd0;
      if (c < 5)       exp_d = 32'h0;
      else if (c < 9)  exp_d = pk(4, 5, 6, 7);
      else if (c < 25) exp_d = pk(90, 91, 92, 93);
      else             exp_d = pk(24, 25, 26, 27);
      checks++;
      if (dout_valid !== exp_v) begin errors++; $display("FAIL frz_valid c=%0d got %b exp %b", c, dout_valid, exp_v); end
      checks++;
      if (dout !== exp_d) begin errors++; $display("FAIL frz_dout c=%0d got %h exp %h", c, dout, exp_d); end
      checks++;
      if (active_mode !== exp_m) begin errors++; $display("FAIL frz_mode c=%0d got %0d exp %0d", c, active_mode, exp_m); end
      mode = (c < 8) ? 2'd1 : (c < 20) ? 2'd3 : 2'd0;
      v    = (c == 6) ? 90 : (c >= 10 && c <= 20) ? 200 : c;
      din  = pk(v, v + 1, v + 2, v + 3);
    end
  endtask

  task automatic test_async_reset;
    logic        exp_v;
    logic [31:0] exp_d;
    do_reset(8'd7, 2'd1);
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) tick;
      if (c == 9) begin
        checks++;
        if (dout !== 32'h33333333) begin errors++; $display("FAIL ar_pre_dout got %h exp %h", dout, 32'h33333333); end
      end
      din = (c <= 8) ? 32'h33333333 : 32'hFAFAFAFA;
    end
    // Mid-cycle pulse in cycle 12 of a max-hold window.
    #1 rst = 1'b1;
    #1;
    checks++;
    if (dout !== 32'h0) begin errors++; $display("FAIL ar_dout got %h exp %h", dout, 32'h0); end
    checks++;
    if (dout_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got %b exp 0", dout_valid); end
    checks++;
    if (active_mode !== 2'd0) begin errors++; $display("FAIL ar_mode got %0d exp 0", active_mode); end
    #1 rst = 1'b0;
    for (int d = 0; d <= 17; d++) begin
      if (d > 0) tick;
      exp_v = (d == 9) || (d == 17);
      if (d < 9)       exp_d = 32'h0;
      else if (d < 17) exp_d = pk(32, 33, 34, 35);
      else             exp_d = pk(100, 101, 102, 103);
      checks++;
      if (dout_valid !== exp_v) begin errors++; $display("FAIL ar_post_valid d=%0d got %b exp %b", d, dout_valid, exp_v); end
      checks++;
      if (dout !== exp_d) begin errors++; $display("FAIL ar_post_dout d=%0d got %h exp %h", d, dout, exp_d); end
      if (d <= 8)       din = pk(40 - d, 41 - d, 42 - d, 43 - d);
      else if (d == 12) din = pk(100, 101, 102, 103);
      else              din = pk(d, d + 1, d + 2, d + 3);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_snapshot;
    test_period_zero;
    test_max_min;
    test_sync;
    test_shrink;
    test_freeze;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
